// File: rtl/frame_buffer.sv
// frame_buffer: double-buffered 3-bit pixel store with background clear and vsync-synchronised bank swap
module frame_buffer #(
  parameter int         FB_DEPTH  = 19200,
  parameter logic [2:0] CLEAR_RGB = 3'b000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] rd_address,
  output logic [2:0]  rd_rgb,
  input  logic        vga_vsync,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [15:0] wr_address,
  input  logic [2:0]  wr_rgb,
  input  logic        clear_req,
  input  logic        swap_req,
  output logic        busy,
  output logic        front_bank
);
  localparam int          AW    = FB_DEPTH > 1 ? $clog2(FB_DEPTH) : 1;
  localparam logic [31:0] DEPTH = FB_DEPTH;
  typedef enum logic [1:0] {IDLE, CLEAR, WAIT_SWAP} state_t;
  state_t        state;
  logic [2:0]    bank0 [FB_DEPTH];
  logic [2:0]    bank1 [FB_DEPTH];
  logic [15:0]   cnt;
  logic          vs_q, pend, vs_fall, wr_en, rd_ok;
  logic [AW-1:0] wr_idx, rd_idx;
  logic [2:0]    wr_data;
  assign vs_fall  = vs_q & ~vga_vsync;
  assign wr_ready = state == IDLE;
  assign busy     = state != IDLE;
  assign rd_ok    = 32'(rd_address) < DEPTH;
  assign rd_idx   = rd_address[AW-1:0];
  always_comb begin
    wr_en   = !reset && (state == CLEAR || (state == IDLE && wr_valid && 32'(wr_address) < DEPTH));
    wr_idx  = state == CLEAR ? cnt[AW-1:0] : wr_address[AW-1:0];
    wr_data = state == CLEAR ? CLEAR_RGB : wr_rgb;
  end
  // writes always land in the bank that is not being displayed
  always_ff @(posedge clock) begin
    if (wr_en && front_bank) bank0[wr_idx] <= wr_data;
    if (wr_en && !front_bank) bank1[wr_idx] <= wr_data;
  end
  always_ff @(posedge clock)
    rd_rgb <= reset || !rd_ok ? 3'b000 : front_bank ? bank1[rd_idx] : bank0[rd_idx];
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      front_bank <= 1'b0;
      vs_q       <= 1'b1;
      pend       <= 1'b0;
      cnt        <= 16'd0;
    end else begin
      vs_q <= vga_vsync;
      case (state)
        IDLE: begin
          if (clear_req) begin
            state <= CLEAR;
            cnt   <= 16'd0;
            pend  <= swap_req;
          end else if (swap_req) state <= WAIT_SWAP;
        end
        CLEAR: begin
          cnt <= cnt + 16'd1;
          if (swap_req) pend <= 1'b1;
          if (32'(cnt) == DEPTH - 32'd1) state <= pend || swap_req ? WAIT_SWAP : IDLE;
        end
        WAIT_SWAP: begin
          if (vs_fall) begin
            front_bank <= ~front_bank;
            pend       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_frame_buffer.sv
// tb_frame_buffer: directed and random checks of frame_buffer against a behavioural bank model
module tb_frame_buffer;
  localparam int         D   = 16;
  localparam logic [2:0] CLR = 3'b110;
  logic clock = 0, reset = 0, vga_vsync = 1, wr_valid = 0, clear_req = 0, swap_req = 0;
  logic [15:0] rd_address = 0, wr_address = 0;
  logic [2:0]  wr_rgb = 0, rd_rgb;
  logic wr_ready, busy, front_bank;
  int vec = 0, bad = 0;
  frame_buffer #(.FB_DEPTH(D), .CLEAR_RGB(CLR)) dut (
    .clock(clock), .reset(reset), .rd_address(rd_address), .rd_rgb(rd_rgb),
    .vga_vsync(vga_vsync), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_address(wr_address), .wr_rgb(wr_rgb), .clear_req(clear_req),
    .swap_req(swap_req), .busy(busy), .front_bank(front_bank));
  always #5 clock = ~clock;
  // model: mode 0 idle, 1 clearing, 2 waiting for vsync fall
  logic [2:0] mem [2][D];
  bit kn [2][D];
  int md = 0, left = 0;
  bit fr = 0, pend = 0, vs_prev = 1, live = 0, rd_k = 0;
  logic [2:0] rd_m = 0;
  always @(posedge clock) begin
    bit fall;
    int b;
    fall = vs_prev && !vga_vsync;
    b = fr ? 0 : 1;
    if (reset) begin
      md = 0; fr = 0; pend = 0; vs_prev = 1; rd_m = 0; rd_k = 1; live = 1;
    end else begin
      rd_k = rd_address >= D || kn[fr][rd_address[3:0]];
      rd_m = rd_address >= D ? 3'b000 : mem[fr][rd_address[3:0]];
      vs_prev = vga_vsync;
      if (md == 0) begin
        if (wr_valid && wr_address < D) begin
          mem[b][wr_address[3:0]] = wr_rgb;
          kn[b][wr_address[3:0]] = 1;
        end
        if (clear_req) begin md = 1; left = D; pend = swap_req; end
        else if (swap_req) md = 2;
      end else if (md == 1) begin
        mem[b][D - left] = CLR;
        kn[b][D - left] = 1;
        left--;
        if (swap_req) pend = 1;
        if (left == 0) md = pend ? 2 : 0;
      end else if (fall) begin
        fr = !fr; md = 0; pend = 0;
      end
    end
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  always @(negedge clock) if (live) begin
    chk("busy", 32'(busy), 32'(md != 0));
    chk("wr_ready", 32'(wr_ready), 32'(md == 0));
    chk("front_bank", 32'(front_bank), 32'(fr));
    if (rd_k) chk("rd_rgb", 32'(rd_rgb), 32'(rd_m));
  end
  task automatic step();
    @(negedge clock);
    clear_req = 0; swap_req = 0; wr_valid = 0; reset = 0;
  endtask
  task automatic fall_edge();
    vga_vsync = 1; step();
    vga_vsync = 0; step();
  endtask
  initial begin
    int n;
    @(negedge clock);
    reset = 1; step();
    chk("rst wr_ready", 32'(wr_ready), 1);
    chk("rst busy", 32'(busy), 0);
    chk("rst front", 32'(front_bank), 0);
    chk("rst rd_rgb", 32'(rd_rgb), 0);
    wr_valid = 1; wr_address = 5; wr_rgb = 3'b101; step();
    swap_req = 1; step();
    fall_edge();
    chk("swap front", 32'(front_bank), 1);
    rd_address = 5; step();
    chk("read 5", 32'(rd_rgb), 32'(3'b101));
    rd_address = 16'hFFFF; step();
    chk("read ffff", 32'(rd_rgb), 0);
    chk("ffff ready", 32'(wr_ready), 1);
    wr_valid = 1; wr_address = 16'hFFFF; wr_rgb = 3'b111; step();
    chk("ffff idle", 32'(busy), 0);
    clear_req = 1; step();
    n = 0;
    while (busy && n < 100) begin
      chk("clear ready", 32'(wr_ready), 0);
      wr_valid = 1; wr_address = 16'(n % D); wr_rgb = 3'b001;
      n++; step();
    end
    chk("clear cycles", n, D);
    clear_req = 1; swap_req = 1; step();
    repeat (D + 6) step();
    chk("hold low busy", 32'(busy), 1);
    chk("hold low front", 32'(front_bank), 1);
    fall_edge();
    chk("one toggle", 32'(front_bank), 0);
    repeat (4) step();
    chk("still one toggle", 32'(front_bank), 0);
    for (int i = 0; i < D; i++) begin
      rd_address = 16'(i); step();
      chk("cleared", 32'(rd_rgb), 32'(CLR));
    end
    swap_req = 1; step();
    fall_edge();
    chk("swap back", 32'(front_bank), 1);
    clear_req = 1; step();
    repeat (3) step();
    chk("mid clear", 32'(busy), 1);
    reset = 1; step();
    chk("abort busy", 32'(busy), 0);
    chk("abort front", 32'(front_bank), 0);
    chk("abort rd_rgb", 32'(rd_rgb), 0);
    for (int c = 0; c < 4000; c++) begin
      wr_valid   = $urandom_range(0, 1);
      wr_address = $urandom_range(0, 15) == 0 ? 16'hFFFF : 16'($urandom_range(0, D + 3));
      wr_rgb     = 3'($urandom);
      rd_address = $urandom_range(0, 15) == 0 ? 16'hFFFF : 16'($urandom_range(0, D + 3));
      clear_req  = $urandom_range(0, 29) == 0;
      swap_req   = $urandom_range(0, 19) == 0;
      if ($urandom_range(0, 7) == 0) vga_vsync = !vga_vsync;
      reset      = $urandom_range(0, 299) == 0;
      step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
